// File: rtl/ervp_memory_cell_nr1w_init_if.sv
// Bundle of init, write and multi-port read signals
// for the swept-init register-file cell.
interface ervp_memory_cell_nr1w_init_if #(
  parameter int BW_INDEX  = 4,
  parameter int WIDTH     = 32,
  parameter int NUM_RPORT = 2,
  parameter int BW_SELECT = 1
);
  logic                          init_req;
  logic                          init_busy;
  logic [BW_INDEX-1:0]           windex;
  logic                          wenable;
  logic [BW_SELECT-1:0]          wpermit;
  logic [WIDTH-1:0]              wdata;
  logic [NUM_RPORT*BW_INDEX-1:0] rindex;
  logic [NUM_RPORT-1:0]          renable;
  logic [NUM_RPORT*WIDTH-1:0]    rdata;
  logic [NUM_RPORT-1:0]          rvalid;

  modport master (
    output init_req, windex, wenable, wpermit,
    output wdata, rindex, renable,
    input  init_busy, rdata, rvalid
  );

  modport slave (
    input  init_req, windex, wenable, wpermit,
    input  wdata, rindex, renable,
    output init_busy, rdata, rvalid
  );
endinterface

// File: rtl/ervp_memory_cell_nr1w_init.sv
// N-read/1-write register file that sweeps INIT_VALUE
// into every entry after reset or on request.
module ervp_memory_cell_nr1w_init #(
  parameter int DEPTH              = 16,
  parameter int WIDTH              = 32,
  parameter int BW_INDEX           = 4,
  parameter int NUM_RPORT          = 2,
  parameter int USE_SUBWORD_ENABLE = 0,
  parameter int BW_SUBWORD         = 8,
  parameter int WRITE_FIRST        = 1,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
  input logic clk,
  input logic rst,
  ervp_memory_cell_nr1w_init_if.slave bus
);
  localparam int BW_SELECT = (USE_SUBWORD_ENABLE == 1)
    ? (WIDTH + BW_SUBWORD - 1) / BW_SUBWORD : 1;
  localparam logic [BW_INDEX:0] DEPTH_L = (BW_INDEX+1)'(DEPTH);
  localparam logic [BW_INDEX-1:0] LAST = BW_INDEX'(DEPTH - 1);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t              state, state_nx;
  logic [BW_INDEX-1:0] clr_idx, clr_idx_nx;
  logic [WIDTH-1:0]    mem [DEPTH];
  logic [WIDTH-1:0]    wmask;
  logic [WIDTH-1:0]    wmerge;
  logic                wr_hit;
  logic [BW_INDEX-1:0] rd_idx [NUM_RPORT];
  logic [WIDTH-1:0]    rd_val [NUM_RPORT];
  logic [NUM_RPORT*WIDTH-1:0] rdata_q;
  logic [NUM_RPORT-1:0]       rvalid_q;

  generate
    if (USE_SUBWORD_ENABLE == 1) begin : g_sub
      for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        assign wmask[b] = bus.wpermit[b / BW_SUBWORD];
      end
    end else begin : g_full
      logic unused_permit;
      assign unused_permit = ^bus.wpermit;
      assign wmask = '1;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else begin
      state   <= state_nx;
      clr_idx <= clr_idx_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    clr_idx_nx = clr_idx;
    unique case (state)
      CLEAR: begin
        clr_idx_nx = clr_idx + 1'b1;
        if (clr_idx == LAST) state_nx = IDLE;
      end
      IDLE: begin
        if (bus.init_req) begin
          state_nx   = CLEAR;
          clr_idx_nx = '0;
        end
      end
      default: state_nx = CLEAR;
    endcase
  end

  assign bus.init_busy = (state == CLEAR);

  assign wr_hit = (state == IDLE) && bus.wenable
    && ({1'b0, bus.windex} < DEPTH_L);
  assign wmerge = (mem[bus.windex] & ~wmask)
    | (bus.wdata & wmask);

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) mem[clr_idx] <= INIT_VALUE;
      else if (wr_hit) mem[bus.windex] <= wmerge;
    end
  end

  // write-first forwarding reuses the merged word so masked lanes stay old
  always_comb begin
    for (int p = 0; p < NUM_RPORT; p++) begin
      rd_idx[p] = bus.rindex[p*BW_INDEX +: BW_INDEX];
      rd_val[p] = '0;
      if ({1'b0, rd_idx[p]} < DEPTH_L) begin
        rd_val[p] = mem[rd_idx[p]];
        if (WRITE_FIRST == 1 && wr_hit
            && bus.windex == rd_idx[p])
          rd_val[p] = wmerge;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      for (int p = 0; p < NUM_RPORT; p++) begin
        rvalid_q[p] <= bus.renable[p] && (state == IDLE);
        if (bus.renable[p] && state == IDLE)
          rdata_q[p*WIDTH +: WIDTH] <= rd_val[p];
      end
    end
  end

  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;
endmodule

// File: tb/tb_ervp_memory_cell_nr1w_init.sv
// Bench: two configurations driven side by side and
// checked every cycle against a behavioural model.
module tb_ervp_memory_cell_nr1w_init;
  localparam logic [31:0] INIT_A = 32'hA5A5_0F0F;
  localparam logic [31:0] INIT_B = 32'h5A5A_1234;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        wen   [2];
  logic [3:0]  widx  [2];
  logic [3:0]  wperm [2];
  logic [31:0] wdat  [2];
  logic [7:0]  ridx  [2];
  logic [1:0]  ren   [2];
  logic        ini   [2];

  ervp_memory_cell_nr1w_init_if #(
    .BW_INDEX(4), .WIDTH(32), .NUM_RPORT(2), .BW_SELECT(4)
  ) ifa ();
  ervp_memory_cell_nr1w_init_if #(
    .BW_INDEX(4), .WIDTH(32), .NUM_RPORT(2), .BW_SELECT(1)
  ) ifb ();

  assign ifa.init_req = ini[0];
  assign ifa.wenable  = wen[0];
  assign ifa.windex   = widx[0];
  assign ifa.wpermit  = wperm[0];
  assign ifa.wdata    = wdat[0];
  assign ifa.rindex   = ridx[0];
  assign ifa.renable  = ren[0];
  assign ifb.init_req = ini[1];
  assign ifb.wenable  = wen[1];
  assign ifb.windex   = widx[1];
  assign ifb.wpermit  = wperm[1][0];
  assign ifb.wdata    = wdat[1];
  assign ifb.rindex   = ridx[1];
  assign ifb.renable  = ren[1];

  ervp_memory_cell_nr1w_init #(
    .DEPTH(16), .WIDTH(32), .BW_INDEX(4), .NUM_RPORT(2),
    .USE_SUBWORD_ENABLE(1), .BW_SUBWORD(8),
    .WRITE_FIRST(1), .INIT_VALUE(INIT_A)
  ) dut_a (.clk(clk), .rst(rst), .bus(ifa));

  ervp_memory_cell_nr1w_init #(
    .DEPTH(12), .WIDTH(32), .BW_INDEX(4), .NUM_RPORT(2),
    .USE_SUBWORD_ENABLE(0), .BW_SUBWORD(8),
    .WRITE_FIRST(0), .INIT_VALUE(INIT_B)
  ) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  logic        ob_busy [2];
  logic [1:0]  ob_rv   [2];
  logic [63:0] ob_rd   [2];
  assign ob_busy[0] = ifa.init_busy;
  assign ob_busy[1] = ifb.init_busy;
  assign ob_rv[0]   = ifa.rvalid;
  assign ob_rv[1]   = ifb.rvalid;
  assign ob_rd[0]   = ifa.rdata;
  assign ob_rd[1]   = ifb.rdata;

  // model: remaining sweep count, contents, expected read regs
  logic [31:0] mm  [2][16];
  int          cnt [2];
  logic [31:0] erd [2][2];
  logic [1:0]  erv [2];

  int ncmp = 0;
  int nbad = 0;
  bit live = 1'b0;

  function automatic int dep(int i);
    return (i == 0) ? 16 : 12;
  endfunction

  function automatic logic [31:0] initv(int i);
    return (i == 0) ? INIT_A : INIT_B;
  endfunction

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nbad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model_step(int i);
    logic [31:0] mask, v;
    logic [3:0]  ix;
    bit          wr;
    int          d;
    d = dep(i);
    if (rst) begin
      cnt[i] = d;
      erv[i] = 2'b00;
      erd[i][0] = '0;
      erd[i][1] = '0;
    end else if (cnt[i] > 0) begin
      mm[i][d - cnt[i]] = initv(i);
      cnt[i]--;
      erv[i] = 2'b00;
    end else begin
      mask = '1;
      if (i == 0)
        for (int s = 0; s < 4; s++)
          if (!wperm[i][s]) mask[s*8 +: 8] = 8'h00;
      wr = wen[i] && (int'(widx[i]) < d);
      for (int p = 0; p < 2; p++) begin
        ix = ridx[i][p*4 +: 4];
        erv[i][p] = ren[i][p];
        if (ren[i][p]) begin
          if (int'(ix) >= d) begin
            erd[i][p] = '0;
          end else begin
            v = mm[i][ix];
            if (i == 0 && wr && widx[i] == ix)
              v = (v & ~mask) | (wdat[i] & mask);
            erd[i][p] = v;
          end
        end
      end
      if (wr)
        mm[i][widx[i]] = (mm[i][widx[i]] & ~mask)
          | (wdat[i] & mask);
      if (ini[i]) cnt[i] = d;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    if (live) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("busy%0d", i), 32'(ob_busy[i]),
            32'(cnt[i] > 0));
        for (int p = 0; p < 2; p++) begin
          chk($sformatf("rvalid%0d.%0d", i, p),
              32'(ob_rv[i][p]), 32'(erv[i][p]));
          chk($sformatf("rdata%0d.%0d", i, p),
              ob_rd[i][p*32 +: 32], erd[i][p]);
        end
      end
    end
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 2; i++) begin
      wen[i] = 0; widx[i] = 0; wperm[i] = 4'hF;
      wdat[i] = 0; ridx[i] = 0; ren[i] = 0; ini[i] = 0;
    end
  endtask

  int nb [2];

  initial begin
    idle_inputs();
    rst = 1;
    live = 1'b1;
    tick();
    rst = 0;
    nb[0] = int'(ob_busy[0]);
    nb[1] = int'(ob_busy[1]);
    // write/read attempts mid-sweep must be dropped
    for (int k = 0; k < 30; k++) begin
      if (k == 3) begin
        wen[0] = 1; widx[0] = 2; wdat[0] = 32'hDEADBEEF;
        ridx[0] = 8'h22; ren[0] = 2'b11;
      end
      tick();
      if (k == 3) begin
        chk("sweep_rvalid", 32'(ob_rv[0]), 32'd0);
        idle_inputs();
      end
      nb[0] += int'(ob_busy[0]);
      nb[1] += int'(ob_busy[1]);
    end
    chk("busy_len_a", nb[0], 16);
    chk("busy_len_b", nb[1], 12);

    for (int e = 0; e < 16; e++) begin
      ren[0] = 2'b11; ren[1] = 2'b11;
      ridx[0] = {4'(e), 4'(e)};
      ridx[1] = {4'(e), 4'(e)};
      tick();
      chk("init_a", ob_rd[0][31:0], INIT_A);
      chk("init_b", ob_rd[1][63:32], (e < 12) ? INIT_B : 32'h0);
      chk("rv_a", 32'(ob_rv[0]), 32'd3);
    end
    idle_inputs();

    wen[0] = 1; widx[0] = 3; wdat[0] = 0;
    tick();
    wperm[0] = 4'b0101; wdat[0] = 32'hAABBCCDD;
    tick();
    idle_inputs();
    ren[0] = 2'b01; ridx[0] = 8'h03;
    tick();
    chk("subword", ob_rd[0][31:0], 32'h00BB00DD);

    for (int i = 0; i < 2; i++) begin
      wen[i] = 1; widx[i] = 5; wdat[i] = 32'h11111111;
      ren[i] = 0;
    end
    tick();
    for (int i = 0; i < 2; i++) begin
      wdat[i] = 32'h22222222; ren[i] = 2'b11; ridx[i] = 8'h55;
    end
    tick();
    chk("fwd_a0", ob_rd[0][31:0], 32'h22222222);
    chk("fwd_a1", ob_rd[0][63:32], 32'h22222222);
    chk("old_b0", ob_rd[1][31:0], 32'h11111111);
    chk("old_b1", ob_rd[1][63:32], 32'h11111111);
    wen[0] = 0; wen[1] = 0;
    tick();
    chk("new_b1", ob_rd[1][63:32], 32'h22222222);

    idle_inputs();
    wen[1] = 1; widx[1] = 13; wdat[1] = 32'h77777777;
    ren[1] = 2'b11; ridx[1] = 8'hDE;
    tick();
    wen[1] = 0;
    tick();
    chk("oor_rd", ob_rd[1][31:0], 32'h0);
    chk("oor_rv", 32'(ob_rv[1]), 32'd3);
    idle_inputs();
    wen[1] = 1; widx[1] = 7; wdat[1] = 32'hCAFEF00D;
    tick();
    idle_inputs();
    ini[1] = 1;
    tick();
    ini[1] = 0;
    nb[1] = int'(ob_busy[1]);
    for (int k = 0; k < 20; k++) begin
      ini[1] = (k == 4);
      tick();
      nb[1] += int'(ob_busy[1]);
    end
    ini[1] = 0;
    chk("reinit_len_b", nb[1], 12);
    ren[1] = 2'b01; ridx[1] = 8'h07;
    tick();
    chk("reinit_b", ob_rd[1][31:0], INIT_B);

    idle_inputs();
    ini[0] = 1;
    tick();
    ini[0] = 0;
    repeat (7) tick();
    rst = 1;
    tick();
    rst = 0;
    nb[0] = int'(ob_busy[0]);
    for (int k = 0; k < 30; k++) begin
      tick();
      nb[0] += int'(ob_busy[0]);
    end
    chk("rst_mid_len", nb[0], 16);

    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < 2; i++) begin
        wen[i]   = $urandom_range(0, 1) == 1;
        widx[i]  = 4'($urandom_range(0, 15));
        wperm[i] = 4'($urandom_range(0, 15));
        wdat[i]  = $urandom;
        ridx[i]  = 8'($urandom_range(0, 255));
        ren[i]   = 2'($urandom_range(0, 3));
        ini[i]   = $urandom_range(0, 63) == 0;
      end
      rst = $urandom_range(0, 199) == 0;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nbad);
    $finish;
  end
endmodule

// File: doc/ervp_memory_cell_nr1w_init.md
ERVP_MEMORY_CELL_NR1W_INIT -- requirements
Module: ervp_memory_cell_nr1w_init

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of entries (>=2, need not be a power of two).
REQ-002 SHALL have parameter WIDTH, default 32, bits per entry.
REQ-003 SHALL have parameter BW_INDEX, default 4, index width (2^BW_INDEX >= DEPTH).
REQ-004 SHALL have parameter NUM_RPORT, default 2, number of independent read ports (1..8).
REQ-005 SHALL have parameter USE_SUBWORD_ENABLE, default 0; when 1, writes are masked per subword.
REQ-006 SHALL have parameter BW_SUBWORD, default 8, subword width; BW_SELECT = ceil(WIDTH/BW_SUBWORD) if USE_SUBWORD_ENABLE==1, else 1.
REQ-007 SHALL have parameter WRITE_FIRST, default 1; when 1, same-cycle write data is forwarded to reads of the same index.
REQ-008 SHALL have parameter INIT_VALUE, default 0, WIDTH-bit value written to every entry by the clear sweep.
REQ-009 SHALL use one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock; rst  input  1  synchronous active-high reset.
REQ-010 init_req  input  1  request a new clear sweep (honoured only in IDLE).
REQ-011 init_busy  output  1  high while the clear sweep runs.
REQ-012 windex  input  BW_INDEX  write index.
REQ-013 wenable  input  1  write strobe.
REQ-014 wpermit  input  BW_SELECT  subword write mask (all-ones behaviour when USE_SUBWORD_ENABLE==0).
REQ-015 wdata  input  WIDTH  write data.
REQ-016 rindex  input  NUM_RPORT*BW_INDEX  packed read indices, port p at bits [p*BW_INDEX +: BW_INDEX].
REQ-017 renable  input  NUM_RPORT  per-port read strobe.
REQ-018 rdata  output  NUM_RPORT*WIDTH  packed registered read data, port p at [p*WIDTH +: WIDTH].
REQ-019 rvalid  output  NUM_RPORT  per-port registered read-valid.

Function
REQ-020 FSM SHALL have states CLEAR and IDLE; sweep counter clr_idx SHALL be BW_INDEX bits.
REQ-021 In CLEAR, each cycle SHALL write INIT_VALUE (all bits) to entry clr_idx, then increment clr_idx; after writing entry DEPTH-1, next state SHALL be IDLE (sweep = exactly DEPTH cycles).
REQ-022 In IDLE, init_req==1 SHALL set clr_idx=0 and enter CLEAR on the next edge.
REQ-023 init_busy SHALL equal (state==CLEAR), a registered signal.
REQ-024 While CLEAR, wenable SHALL be ignored (no memory update) and renable SHALL produce rvalid=0 with rdata unchanged.
REQ-025 In IDLE, wenable=1 with windex<DEPTH SHALL update, at the edge, bits of subword s only where wpermit[s]==1; windex>=DEPTH SHALL be ignored.
REQ-026 Read latency SHALL be 1 cycle: renable[p]=1 in IDLE at cycle t SHALL give rvalid[p]=1 and rdata port p = entry content at cycle t+1.
REQ-027 renable[p]=0 SHALL give rvalid[p]=0 next cycle and SHALL hold rdata port p unchanged.
REQ-028 rindex[p]>=DEPTH with renable[p]=1 SHALL give rvalid[p]=1 and rdata port p = 0.
REQ-029 Simultaneous write and read of the same valid index in IDLE: WRITE_FIRST==1 SHALL return new data for permitted subwords and old data for masked subwords; WRITE_FIRST==0 SHALL return old data.
REQ-030 Multiple ports reading the same index in the same cycle SHALL all return identical data.
REQ-031 init_req while CLEAR SHALL be ignored (sweep neither restarts nor extends).

Reset
REQ-032 rst=1 at an edge SHALL set state=CLEAR, clr_idx=0, init_busy=1, rvalid=0, rdata=0; memory contents are not reset directly but are overwritten by the ensuing sweep.
REQ-033 rst asserted mid-sweep or mid-operation SHALL restart the sweep at entry 0; rst has priority over init_req and all writes/reads.

Verification
REQ-034 Reset then idle: rst high 1 cycle, DEPTH=16 -> init_busy high exactly 16 cycles, then 0; read all entries -> each rdata = INIT_VALUE, rvalid=1 one cycle after renable.
REQ-035 Subword write: USE_SUBWORD_ENABLE=1, WIDTH=32, entry 3 = 0, write 0xAABBCCDD, wpermit=4'b0101 -> read of 3 = 0x00BB00DD.
REQ-036 Forwarding: WRITE_FIRST=1, entry 5 = 0x11111111, same cycle write 0x22222222 to 5 and read 5 on both ports -> both ports 0x22222222; WRITE_FIRST=0 -> both 0x11111111, later read 0x22222222.
REQ-037 Busy masking: during sweep, wenable to index 2 with 0xDEADBEEF and renable -> rvalid=0; after sweep, entry 2 = INIT_VALUE.
REQ-038 Out-of-range and re-init: DEPTH=12, write index 13 ignored, read index 14 -> 0 with rvalid=1; init_req in IDLE -> init_busy for 12 cycles, previously written entries read INIT_VALUE.
REQ-039 Reset mid-sweep: rst pulsed at sweep cycle 7 -> init_busy stays high a further full DEPTH cycles from that edge.
